// File: rtl/bin2dig_writer.sv
// Binary to eight-digit BCD converter using serial double dabble, then one digit
// write per clock on the pos/dig bus for the downstream seven-segment controller.
module bin2dig_writer #(
  parameter int WIDTH = 27,
  parameter int NDIG  = 8
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] value_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [3:0]       dig_o,
  output logic [3:0]       pos_o
);

  localparam int BW = NDIG * 4;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(10 ** NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    bcd_adj;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, ovf_q;
  logic [3:0]       dig_q, pos_q;
  logic             over;

  assign over = (value_i > MAX_VAL);

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < NDIG; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= 4'hF;
      pos_q   <= 4'hF;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            ovf_q   <= over;
            shreg_q <= over ? MAX_VAL : value_i;
            bcd_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CONV: begin
          bcd_q   <= {bcd_adj[BW-2:0], shreg_q[WIDTH-1]};
          shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
          cnt_q   <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            cnt_q   <= CW'(NDIG);
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          // digits leave LSB-first; position is derived from the remaining count
          if (cnt_q == '0) begin
            pos_q   <= 4'hF;
            dig_q   <= 4'hF;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            pos_q <= 4'(NDIG - int'(cnt_q));
            dig_q <= bcd_q[3:0];
            bcd_q <= bcd_q >> 4;
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign dig_o      = dig_q;
  assign pos_o      = pos_q;

endmodule

// File: tb/tb_bin2dig_writer.sv
// Directed and random checks of bin2dig_writer against a divide-by-ten digit model,
// including cycle-exact write timing, ignored restarts and mid-operation reset.
module tb_bin2dig_writer;

  localparam int W = 27;
  localparam int N = 8;
  localparam int unsigned MAXD = 99999999;

  logic          clock, reset_n, start, busy, done, ovf;
  logic [W-1:0]  value;
  logic [3:0]    dig, pos;
  int            n_total = 0, n_pass = 0, n_fail = 0;

  bin2dig_writer #(.WIDTH(W), .NDIG(N)) dut (
    .clock_i(clock), .reset_ni(reset_n), .value_i(value), .start_i(start),
    .busy_o(busy), .done_o(done), .overflow_o(ovf), .dig_o(dig), .pos_o(pos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_digit(input int unsigned v, input int i);
    int unsigned x = (v > MAXD) ? MAXD : v;
    for (int k = 0; k < i; k++) x = x / 10;
    return x % 10;
  endfunction

  task automatic launch(input int unsigned v);
    start = 1'b1;
    value = W'(v);
    @(negedge clock);
    start = 1'b0;
    value = W'($urandom);
  endtask

  // Called at the first negedge after the accepting edge; returns in the done cycle.
  // inj 1/2 pulses start with value 42 during CONV / EMIT, which must be ignored.
  task automatic check_conv(input int unsigned v, input int inj);
    for (int m = 0; m <= W + N + 1; m++) begin
      chk($sformatf("busy v=%0d m=%0d", v, m), busy, (m <= W + N) ? 1 : 0);
      chk($sformatf("done v=%0d m=%0d", v, m), done, (m == W + N + 1) ? 1 : 0);
      chk($sformatf("ovf v=%0d m=%0d", v, m), ovf, (v > MAXD) ? 1 : 0);
      if (m >= W + 1 && m <= W + N) begin
        chk($sformatf("pos v=%0d m=%0d", v, m), pos, m - W - 1);
        chk($sformatf("dig v=%0d m=%0d", v, m), dig, ref_digit(v, m - W - 1));
      end else begin
        chk($sformatf("idle pos v=%0d m=%0d", v, m), pos, 15);
        chk($sformatf("idle dig v=%0d m=%0d", v, m), dig, 15);
      end
      if (m < W + N + 1) begin
        if ((inj == 1 && m == 5) || (inj == 2 && m == W + 4)) begin
          start = 1'b1;
          value = W'(42);
        end else begin
          start = 1'b0;
        end
        @(negedge clock);
      end
    end
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("idle busy", busy, 0);
      chk("idle pos", pos, 15);
    end
  endtask

  task automatic reset_at(input int unsigned v, input int mstop);
    launch(v);
    for (int m = 0; m < mstop; m++) @(negedge clock);
    if (mstop == W + 4) chk("pre-reset pos", pos, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst ovf", ovf, 0);
    chk("rst pos", pos, 15);
    chk("rst dig", dig, 15);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("held pos", pos, 15);
      chk("held dig", dig, 15);
    end
    reset_n = 1'b1;
    idle_cycles(12);
    launch(7);
    check_conv(7, 0);
    idle_cycles(2);
  endtask

  initial begin
    int unsigned v;
    reset_n = 1'b0;
    start   = 1'b0;
    value   = '0;
    repeat (3) @(negedge clock);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset ovf", ovf, 0);
    chk("reset pos", pos, 15);
    chk("reset dig", dig, 15);
    reset_n = 1'b1;
    @(negedge clock);

    launch(12345678);   check_conv(12345678, 0);  idle_cycles(2);
    launch(0);          check_conv(0, 0);         idle_cycles(1);
    launch(99999999);   check_conv(99999999, 0);  idle_cycles(1);
    launch(100000000);  check_conv(100000000, 0); idle_cycles(1);
    launch(134217727);  check_conv(134217727, 0); idle_cycles(1);
    launch(5);          check_conv(5, 0);         idle_cycles(1);

    launch(1234);       check_conv(1234, 1);      idle_cycles(1);
    launch(87654321);   check_conv(87654321, 2);
    launch(42);         check_conv(42, 0);        idle_cycles(2);

    reset_at(134217727, 10);
    reset_at(24681357, W + 4);

    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0) ? $urandom_range(0, 134217727) : $urandom_range(0, 99999999);
      launch(v);
      check_conv(v, 0);
      if (i % 3 == 0) idle_cycles(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
